// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared line-wide memory port between ICache (req 0) and DCache (req 1).
// Optional CACHE_ARB_DCACHE_PRIORITY_EN: DCache wins every IDLE tie instead of round-robin.
module cache_mem_arbiter #(
    parameter int HOLDOFF_CYCLES = 1,
    parameter int LINE_BITS      = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    localparam logic [1:0] HOLD_INIT = 2'(HOLDOFF_CYCLES);

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;   // 1 = DCache served last
    logic                 grant_d_q, grant_d_d;         // 1 = DCache owns the port
    logic [1:0]           i_hold_cnt_q, i_hold_cnt_d;
    logic [1:0]           d_hold_cnt_q, d_hold_cnt_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

    logic eff_i, eff_d, pick_d, fwd;

    assign eff_i = i_req && (i_hold_cnt_q == 2'd0);
    assign eff_d = d_req && (d_hold_cnt_q == 2'd0);

`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
    assign pick_d = eff_d;
`else
    assign pick_d = eff_d && (!eff_i || !last_grant_q);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d_d    = grant_d_q;
        i_hold_cnt_d = i_hold_cnt_q;
        d_hold_cnt_d = d_hold_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (i_hold_cnt_q != 2'd0) i_hold_cnt_d = i_hold_cnt_q - 2'd1;
        if (d_hold_cnt_q != 2'd0) d_hold_cnt_d = d_hold_cnt_q - 2'd1;

        case (state_q)
            IDLE: begin
                if (eff_i || eff_d) begin
                    grant_d_d   = pick_d;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_d ? d_we : 1'b0;
                    mem_addr_d  = pick_d ? d_addr : i_addr;
                    mem_wdata_d = pick_d ? d_wdata : '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (mem_ready) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    last_grant_d = grant_d_q;
                    // the winner's stale re-driven req gets masked from here
                    if (grant_d_q) d_hold_cnt_d = HOLD_INIT;
                    else           i_hold_cnt_d = HOLD_INIT;
                    state_d      = HOLDOFF;
                end
            end
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_d_q    <= 1'b0;
            i_hold_cnt_q <= 2'd0;
            d_hold_cnt_q <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_d_q    <= grant_d_d;
            i_hold_cnt_q <= i_hold_cnt_d;
            d_hold_cnt_q <= d_hold_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // completion is forwarded only while a transaction is actually granted
    assign fwd       = (state_q == GRANT) && mem_ready;
    assign i_ready   = fwd && !grant_d_q;
    assign d_ready   = fwd && grant_d_q;
    assign i_rdata   = i_ready ? mem_rdata : '0;
    assign d_rdata   = d_ready ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a timestamp-based reference model.
module tb_cache_mem_arbiter;
    localparam int H = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         i_req, d_req, d_we, mem_ready;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wdata, mem_rdata;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic         i_ready, d_ready, mem_req, mem_we, busy;
    logic [31:0]  mem_addr;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.HOLDOFF_CYCLES(H), .LINE_BITS(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        #7;
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        clear_inputs();
        #2 rst_n = 0;
        #3;
        checks++;
        if ({mem_req, mem_we, busy, i_ready, d_ready, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_during: outputs=%b/%b/%b addr=%h required all 0", mem_req, mem_we, busy, mem_addr);
        end
        @(negedge clk);
        rst_n = 1;
        sample();
        checks++;
        if ({mem_req, mem_we, busy, i_ready, d_ready, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_after: req=%b we=%b busy=%b addr=%h required all 0", mem_req, mem_we, busy, mem_addr);
        end
    endtask

    task automatic test_icache_miss();
        logic [127:0] pat;
        pat = {16{8'hA5}};
        tick(); i_req = 1; i_addr = 32'h0000_1230;
        sample();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL imiss_early: mem_req=%b required 0", mem_req); end
        tick(); sample();
        checks++;
        if ({mem_req, mem_we, busy, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h0000_1230}) begin
            errors++;
            $display("FAIL imiss_grant: req=%b we=%b busy=%b addr=%h required 1 0 1 00001230", mem_req, mem_we, busy, mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick(); sample();
            checks++;
            if ({mem_req, mem_addr, i_ready, d_ready} !== {1'b1, 32'h0000_1230, 2'b00}) begin
                errors++;
                $display("FAIL imiss_hold: req=%b addr=%h i_ready=%b d_ready=%b required 1 00001230 0 0", mem_req, mem_addr, i_ready, d_ready);
            end
        end
        tick(); mem_ready = 1; mem_rdata = pat;
        sample();
        checks++;
        if ({i_ready, d_ready, i_rdata, d_rdata} !== {2'b10, pat, 128'h0}) begin
            errors++;
            $display("FAIL imiss_ready: i_ready=%b d_ready=%b i_rdata=%h d_rdata=%h", i_ready, d_ready, i_rdata, d_rdata);
        end
        tick(); mem_ready = 0; i_req = 0;
        sample();
        checks++;
        if ({i_ready, i_rdata, mem_req, busy} !== {1'b0, 128'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL imiss_holdoff: i_ready=%b req=%b busy=%b required 0 0 1", i_ready, mem_req, busy);
        end
        tick(); sample();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL imiss_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_dcache_write();
        logic [127:0] wd;
        int pulses;
        wd = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        pulses = 0;
        tick(); d_req = 1; d_we = 1; d_addr = 32'h0000_8000; d_wdata = wd;
        sample();
        for (int k = 0; k < 4; k++) begin
            tick(); sample();
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h0000_8000, wd}) begin
                errors++;
                $display("FAIL dwr_cmd: req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (d_ready === 1'b1) pulses++;
        end
        tick(); mem_ready = 1; mem_rdata = rand128();
        sample();
        if (d_ready === 1'b1) pulses++;
        checks++;
        if ({d_ready, i_ready, d_rdata} !== {2'b10, mem_rdata}) begin
            errors++;
            $display("FAIL dwr_ready: d_ready=%b i_ready=%b d_rdata=%h", d_ready, i_ready, d_rdata);
        end
        tick(); mem_ready = 0; d_req = 0; d_we = 0;
        sample();
        if (d_ready === 1'b1) pulses++;
        tick(); sample();
        if (d_ready === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || {mem_req, mem_we, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL dwr_done: d_ready pulses=%0d we=%b wdata=%h required 1 0 0", pulses, mem_we, mem_wdata);
        end
    endtask

    task automatic test_tie_from_reset();
        logic [31:0] first_a, second_a;
        logic        first_is_d;
        int          low;
`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
        first_is_d = 1'b1;
`else
        first_is_d = 1'b0;
`endif
        first_a  = first_is_d ? 32'h0000_4440 : 32'h0000_7770;
        second_a = first_is_d ? 32'h0000_7770 : 32'h0000_4440;
        clear_inputs();
        rst_n = 0;
        i_req = 1; i_addr = 32'h0000_7770;
        d_req = 1; d_we = 0; d_addr = 32'h0000_4440;
        #7;
        @(negedge clk);
        rst_n = 1;
        sample();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, first_a}) begin
            errors++;
            $display("FAIL tie_first: req=%b addr=%h required 1 %h", mem_req, mem_addr, first_a);
        end
        tick(); mem_ready = 1; mem_rdata = rand128();
        sample();
        checks++;
        if ({i_ready, d_ready} !== (first_is_d ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL tie_first_ready: i_ready=%b d_ready=%b", i_ready, d_ready);
        end
        tick(); mem_ready = 0;
        if (first_is_d) d_req = 0; else i_req = 0;
        sample();
        low = 0;
        while (mem_req !== 1'b1 && low < 20) begin
            low++;
            tick(); sample();
        end
        checks++;
        if (low != 2 || mem_addr !== second_a) begin
            errors++;
            $display("FAIL tie_second: low cycles=%0d addr=%h required 2 %h", low, mem_addr, second_a);
        end
        tick(); mem_ready = 1;
        sample();
        checks++;
        if ({i_ready, d_ready} !== (first_is_d ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL tie_second_ready: i_ready=%b d_ready=%b", i_ready, d_ready);
        end
        tick(); clear_inputs();
        tick(); tick();
    endtask

    task automatic test_stale();
        logic [127:0] wd;
        int           wait_c, extra;
        wd = rand128();
        tick(); i_req = 1; i_addr = 32'h0000_0C00;
        sample();
        tick(); d_req = 1; d_we = 1; d_addr = 32'h0000_0D00; d_wdata = wd;
        sample();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0C00}) begin
            errors++;
            $display("FAIL stale_igrant: req=%b addr=%h required 1 00000c00", mem_req, mem_addr);
        end
        tick(); mem_ready = 1; mem_rdata = rand128();
        sample();
        tick(); mem_ready = 0;
        sample();
        tick(); i_req = 0;
        sample();
        wait_c = 0;
        while (mem_req !== 1'b1 && wait_c < 20) begin
            wait_c++;
            tick(); sample();
        end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h0000_0D00, wd}) begin
            errors++;
            $display("FAIL stale_dgrant: req=%b we=%b addr=%h required 1 1 00000d00", mem_req, mem_we, mem_addr);
        end
        tick(); mem_ready = 1;
        sample();
        tick(); mem_ready = 0; d_req = 0; d_we = 0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (mem_req === 1'b1) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL stale_no_reissue: mem_req high cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        tick(); i_req = 1; i_addr = 32'h0000_ABC0;
        sample();
        tick(); sample();
        #2 rst_n = 0; mem_ready = 1; mem_rdata = rand128();
        #1;
        checks++;
        if ({mem_req, mem_we, busy, i_ready, d_ready, mem_addr, mem_wdata, i_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid: req=%b busy=%b i_ready=%b addr=%h required all 0", mem_req, busy, i_ready, mem_addr);
        end
        @(negedge clk);
        rst_n = 1; mem_ready = 0;
        sample();
        checks++;
        if ({mem_req, mem_addr, i_ready} !== {1'b1, 32'h0000_ABC0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_regrant: req=%b addr=%h required 1 0000abc0", mem_req, mem_addr);
        end
        tick(); mem_ready = 1;
        sample();
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== mem_rdata) begin
            errors++;
            $display("FAIL rst_mid_ready: i_ready=%b i_rdata=%h", i_ready, i_rdata);
        end
        tick(); clear_inputs();
        tick(); tick();
    endtask

    // Reference model: a transaction starts the cycle after an idle cycle with an
    // unmasked request, ends the cycle after mem_ready, and is followed by one quiet cycle.
    task automatic test_random(input int n);
        bit           act;
        bit           win_d, last_d, ei, ed, exp_i, exp_d, exp_busy;
        logic [31:0]  e_addr;
        bit           e_we;
        logic [127:0] e_wd;
        int           done_cyc, i_rc, d_rc;
        logic         p_ireq, p_dreq, p_dwe, p_mrdy, p_irdy, p_drdy;
        logic [31:0]  p_iaddr, p_daddr;
        logic [127:0] p_dwd;
        int           i_st, i_gap, d_st, d_gap, m_dly;
        bit           m_resp;

        clear_inputs();
        pulse_reset();
        act = 0; last_d = 1; done_cyc = -10; i_rc = -100; d_rc = -100;
        win_d = 0; e_addr = '0; e_we = 0; e_wd = '0;
        p_ireq = 0; p_dreq = 0; p_dwe = 0; p_mrdy = 0; p_irdy = 0; p_drdy = 0;
        p_iaddr = '0; p_daddr = '0; p_dwd = '0;
        i_st = 0; i_gap = 1; d_st = 0; d_gap = 2; m_dly = 0; m_resp = 0;

        for (int c = 0; c < n; c++) begin
            tick();
            if (i_st == 1 && p_irdy) begin
                if ($urandom_range(1, 0) == 1) i_st = 2;
                else begin i_req = 0; i_st = 0; i_gap = $urandom_range(3, 0); end
            end else if (i_st == 2) begin
                i_req = 0; i_st = 0; i_gap = $urandom_range(3, 0);
            end else if (i_st == 0) begin
                if (i_gap == 0) begin i_req = 1; i_addr = {$urandom_range(32'h0FFF_FFFF, 0), 4'h0}; i_st = 1; end
                else i_gap--;
            end
            if (d_st == 1 && p_drdy) begin
                if ($urandom_range(1, 0) == 1) d_st = 2;
                else begin d_req = 0; d_st = 0; d_gap = $urandom_range(3, 0); end
            end else if (d_st == 2) begin
                d_req = 0; d_st = 0; d_gap = $urandom_range(3, 0);
            end else if (d_st == 0) begin
                if (d_gap == 0) begin
                    d_req = 1; d_we = 1'($urandom_range(1, 0));
                    d_addr = {$urandom_range(32'h0FFF_FFFF, 0), 4'h0}; d_wdata = rand128(); d_st = 1;
                end else d_gap--;
            end
            if (mem_req === 1'b1) begin
                if (!m_resp && m_dly == 0) begin mem_ready = 1; mem_rdata = rand128(); m_resp = 1; end
                else begin mem_ready = 0; if (m_dly > 0) m_dly--; end
            end else begin
                m_resp = 0; m_dly = $urandom_range(3, 0);
                mem_ready = ($urandom_range(7, 0) == 0);
                mem_rdata = rand128();
            end

            if (act && p_mrdy) begin
                act = 0; done_cyc = c - 1; last_d = win_d;
            end else if (!act && (c - 1) >= done_cyc + 2) begin
                ei = p_ireq && !((c - 1 - i_rc) >= 1 && (c - 1 - i_rc) <= H);
                ed = p_dreq && !((c - 1 - d_rc) >= 1 && (c - 1 - d_rc) <= H);
                if (ei || ed) begin
`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
                    win_d = ed;
`else
                    win_d = ed && (!ei || !last_d);
`endif
                    act    = 1;
                    e_addr = win_d ? p_daddr : p_iaddr;
                    e_we   = win_d ? p_dwe : 1'b0;
                    e_wd   = win_d ? p_dwd : 128'h0;
                end
            end

            sample();
            exp_i    = act && !win_d && mem_ready;
            exp_d    = act && win_d && mem_ready;
            exp_busy = act || (c == done_cyc + 1);
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {act, act && e_we, act ? e_addr : 32'h0, act ? e_wd : 128'h0}) begin
                errors++;
                $display("FAIL rnd_cmd c=%0d: req=%b we=%b addr=%h required %b %b %h", c, mem_req, mem_we, mem_addr, act, e_we, e_addr);
            end
            checks++;
            if ({i_ready, d_ready, busy} !== {exp_i, exp_d, exp_busy}) begin
                errors++;
                $display("FAIL rnd_ctrl c=%0d: i_ready=%b d_ready=%b busy=%b required %b %b %b", c, i_ready, d_ready, busy, exp_i, exp_d, exp_busy);
            end
            checks++;
            if ({i_rdata, d_rdata} !== {exp_i ? mem_rdata : 128'h0, exp_d ? mem_rdata : 128'h0}) begin
                errors++;
                $display("FAIL rnd_rdata c=%0d: i_rdata=%h d_rdata=%h", c, i_rdata, d_rdata);
            end
            if (exp_i) i_rc = c;
            if (exp_d) d_rc = c;
            p_ireq = i_req; p_iaddr = i_addr; p_dreq = d_req; p_dwe = d_we; p_daddr = d_addr;
            p_dwd = d_wdata; p_mrdy = mem_ready; p_irdy = i_ready; p_drdy = d_ready;
        end
        tick(); clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_icache_miss();
        test_dcache_write();
        test_tie_from_reset();
        test_stale();
        test_reset_mid();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
